obi_mux_rr_2_to_1: RTL and testbench
====================================

# obi_mux_rr_2_to_1

Two-master to one-slave OBI arbiter with round-robin fairness and pipelined read responses. It sits between two OBI masters and one shared OBI slave, for example an instruction port and a data port sharing one memory. It allows up to DEPTH reads outstanding at the slave and routes each `rvalid`/`rdata` back to the master that issued the read, using an in-order source-ID FIFO. Writes produce no response phase and are never tracked.

## Interface
- `DEPTH`, 2: maximum number of outstanding reads.
  - Power of two, at least 1.
  - Sets the source-ID FIFO depth.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `pri_req_i`, `pri_gnt_o`, `pri_addr_i`[31:0], `pri_we_i`, `pri_be_i`[3:0], `pri_wdata_i`[31:0], `pri_rvalid_o`, `pri_rdata_o`[31:0]: master port 0 (OBI).
- `sec_req_i`, `sec_gnt_o`, `sec_addr_i`[31:0], `sec_we_i`, `sec_be_i`[3:0], `sec_wdata_i`[31:0], `sec_rvalid_o`, `sec_rdata_o`[31:0]: master port 1 (OBI).
- `shr_req_o`, `shr_gnt_i`, `shr_addr_o`[31:0], `shr_we_o`, `shr_be_o`[3:0], `shr_wdata_o`[31:0], `shr_rvalid_i`, `shr_rdata_i`[31:0]: slave port (OBI).
- `outstanding_o` output $clog2(DEPTH+1): number of reads currently in flight.

## Operation
- **State:**
  - `last` (1 bit; 0 = pri, 1 = sec).
  - `lock` (1 bit) and `lock_owner` (1 bit).
  - Source-ID FIFO: DEPTH entries of 1 bit, with read pointer, write pointer and count.
- **Owner selection (combinational):**
  - If `lock`=1, the owner is `lock_owner`.
  - Otherwise, if only one master requests, that master is owner.
  - If both request, the owner is the master not equal to `last`.
  - If neither requests, the owner is pri and `shr_req_o`=0.
- **Address mux:** `shr_req_o`/`addr`/`we`/`be`/`wdata` carry the owner's signals.
- **Grant gating:**
  - `full` = (count == DEPTH).
  - Effective grant is `shr_gnt_i && !full`.
  - `full` blocks the grant even if `shr_rvalid_i` pops an entry in the same cycle.
  - Effective grant drives only the owner's `gnt_o`; the non-owner's `gnt_o` is 0.
  - While `full`, `shr_req_o` is still asserted (slave may assert gnt; the master is not granted). This is accepted; integration must ensure the slave does not consume a request without the mux granting it.
- **Handshake:** owner request and effective grant in the same cycle.
  - `last` <= owner.
  - `lock` <= 0.
  - If `we`=0, push the owner ID into the FIFO.
- **Lock rule:**
  - `lock` <= 1 and `lock_owner` <= owner when `shr_req_o`=1 with no handshake.
  - This keeps the slave-side address stable until grant, as OBI requires.
  - If the locked owner deasserts req (protocol violation), `lock` clears the next cycle.
- **Response routing:**
  - On `shr_rvalid_i`=1 with count>0, pop the FIFO head.
  - If the head is 0, `pri_rvalid_o`=1 and `pri_rdata_o`=`shr_rdata_i`. If the head is 1, the same applies to sec.
  - The other master's rvalid and rdata are 0.
  - Push and pop in the same cycle leave count unchanged; both pointers advance.
- **Spurious rvalid:** `shr_rvalid_i` with count=0 is dropped. Both rvalid outputs stay 0 and state is unchanged.
- **Pointers:** log2(DEPTH) bits, wrapping naturally. For DEPTH=1 the pointers are unused; a single entry plus the count is used.
- **Reset, asserted at any time, including mid-transaction:**
  - Immediately: `last`=1, so pri wins the first tie. `lock`=0. FIFO empty, count 0.
  - While `rst_i`=1: `pri_gnt_o`=`sec_gnt_o`=0, `shr_req_o`=0, all rvalid outputs 0, all rdata outputs 0, `outstanding_o`=0.
  - In-flight responses are discarded.

## Timing
- Grant path is combinational: `shr_gnt_i` to `*_gnt_o`, zero cycles.
- Address mux is combinational: zero cycles.
- Response routing is combinational, in the same cycle as `shr_rvalid_i`.
- `outstanding_o` updates one cycle after a push or pop.
- **Throughput:** one read accepted per cycle until count = DEPTH. The earliest response is the cycle after its grant.
- **Alternation:** with both masters continuously requesting and the slave always granting, grants alternate every cycle: pri, sec, pri, …
- A write handshake updates `last` exactly like a read handshake.

## Test plan
- **Reset and tie:** after reset, both masters request reads and `shr_gnt_i`=1 constantly.
  - Required: grants follow the sequence pri, sec, pri, sec.
  - Responses returned with 1-cycle latency route in that same order.
- **FIFO full:** DEPTH=2, slave grants but withholds rvalid.
  - Required: two reads are granted and `outstanding_o`=2.
  - The third read is not granted while `shr_gnt_i`=1 and `shr_req_o` stays high.
  - After one rvalid, the third read is granted the next cycle.
- **Lock:** pri requests alone and `shr_gnt_i`=0 for 3 cycles; sec raises req in cycle 1.
  - Required: `shr_addr_o` = `pri_addr_i` for all 3 cycles, and pri is granted when `shr_gnt_i`=1.
  - Sec is granted next.
- **Mixed writes and reads:** sequence sec write, pri read, sec read, with out-of-phase response delays of 2 cycles.
  - Required: exactly 2 responses, to pri then sec, with matching rdata; the write produces no rvalid.
- **Same-cycle push/pop:** count=1, a new read is granted in the same cycle that rvalid pops.
  - Required: count stays 1 and the next rvalid routes to the new requester.
- **Async reset:** assert `rst_i` mid-cycle with count=2.
  - Required: gnt, req, rvalid and `outstanding_o` go to 0 immediately, without waiting for a clock edge.
  - A later `shr_rvalid_i` after reset is dropped.

Source files
------------

// File: rtl/obi_mux_rr_2_to_1.sv
// Two-master to one-slave OBI arbiter: round-robin owner selection, address lock until grant,
// and an in-order source-ID FIFO that routes pipelined read responses back to their issuer.
//   state       | meaning
//   last_q      | master of the most recent handshake (0 = pri, 1 = sec)
//   lock_q      | slave-side request pending without grant; owner held in lock_owner_q
module obi_mux_rr_2_to_1 #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         pri_req_i,
  output logic                         pri_gnt_o,
  input  logic [31:0]                  pri_addr_i,
  input  logic                         pri_we_i,
  input  logic [3:0]                   pri_be_i,
  input  logic [31:0]                  pri_wdata_i,
  output logic                         pri_rvalid_o,
  output logic [31:0]                  pri_rdata_o,
  input  logic                         sec_req_i,
  output logic                         sec_gnt_o,
  input  logic [31:0]                  sec_addr_i,
  input  logic                         sec_we_i,
  input  logic [3:0]                   sec_be_i,
  input  logic [31:0]                  sec_wdata_i,
  output logic                         sec_rvalid_o,
  output logic [31:0]                  sec_rdata_o,
  output logic                         shr_req_o,
  input  logic                         shr_gnt_i,
  output logic [31:0]                  shr_addr_o,
  output logic                         shr_we_o,
  output logic [3:0]                   shr_be_o,
  output logic [31:0]                  shr_wdata_o,
  input  logic                         shr_rvalid_i,
  input  logic [31:0]                  shr_rdata_i,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             last_q, last_d;
  logic             lock_q, lock_d;
  logic             lock_owner_q, lock_owner_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic owner, own_req, own_we, full, eff_gnt, hs, push, pop, head;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q       <= 1'b1;
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      fifo_q       <= '0;
      rptr_q       <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
    end else begin
      last_q       <= last_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      fifo_q       <= fifo_d;
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // A locked owner wins outright; otherwise a tie goes to whoever did not win last.
  always_comb begin
    if (lock_q)                       owner = lock_owner_q;
    else if (pri_req_i && sec_req_i)  owner = ~last_q;
    else                              owner = sec_req_i;
    own_req = owner ? sec_req_i : pri_req_i;
    own_we  = owner ? sec_we_i  : pri_we_i;
    full    = (cnt_q == CW'(DEPTH));
    eff_gnt = shr_gnt_i && !full && !rst_i;
    hs      = own_req && eff_gnt;
    push    = hs && !own_we;
    pop     = shr_rvalid_i && (cnt_q != '0) && !rst_i;
    head    = fifo_q[rptr_q];
  end

  always_comb begin
    last_d       = hs ? owner : last_q;
    lock_d       = own_req && !hs;
    lock_owner_d = (own_req && !hs) ? owner : lock_owner_q;
    fifo_d       = fifo_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q;
    if (push) begin
      fifo_d[wptr_q] = owner;
      wptr_d         = (DEPTH == 1) ? '0 : wptr_q + PW'(1);
    end
    if (pop) rptr_d = (DEPTH == 1) ? '0 : rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    shr_req_o     = own_req && !rst_i;
    shr_addr_o    = owner ? sec_addr_i  : pri_addr_i;
    shr_we_o      = own_we;
    shr_be_o      = owner ? sec_be_i    : pri_be_i;
    shr_wdata_o   = owner ? sec_wdata_i : pri_wdata_i;
    pri_gnt_o     = eff_gnt && !owner;
    sec_gnt_o     = eff_gnt && owner;
    pri_rvalid_o  = pop && !head;
    sec_rvalid_o  = pop && head;
    pri_rdata_o   = pri_rvalid_o ? shr_rdata_i : '0;
    sec_rdata_o   = sec_rvalid_o ? shr_rdata_i : '0;
    outstanding_o = cnt_q;
  end

endmodule

// File: tb/tb_obi_mux_rr_2_to_1.sv
// Self-checking bench for obi_mux_rr_2_to_1: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model of the arbiter.
module tb_obi_mux_rr_2_to_1;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pri_req_i, pri_gnt_o, pri_we_i, pri_rvalid_o;
  logic [31:0] pri_addr_i, pri_wdata_i, pri_rdata_o;
  logic [3:0]  pri_be_i;
  logic        sec_req_i, sec_gnt_o, sec_we_i, sec_rvalid_o;
  logic [31:0] sec_addr_i, sec_wdata_i, sec_rdata_o;
  logic [3:0]  sec_be_i;
  logic        shr_req_o, shr_gnt_i, shr_we_o, shr_rvalid_i;
  logic [31:0] shr_addr_o, shr_wdata_o, shr_rdata_i;
  logic [3:0]  shr_be_o;
  logic [$clog2(DEPTH+1)-1:0] outstanding_o;

  always #5 clk_i = ~clk_i;

  obi_mux_rr_2_to_1 #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pri_req_i(pri_req_i), .pri_gnt_o(pri_gnt_o), .pri_addr_i(pri_addr_i), .pri_we_i(pri_we_i),
    .pri_be_i(pri_be_i), .pri_wdata_i(pri_wdata_i), .pri_rvalid_o(pri_rvalid_o), .pri_rdata_o(pri_rdata_o),
    .sec_req_i(sec_req_i), .sec_gnt_o(sec_gnt_o), .sec_addr_i(sec_addr_i), .sec_we_i(sec_we_i),
    .sec_be_i(sec_be_i), .sec_wdata_i(sec_wdata_i), .sec_rvalid_o(sec_rvalid_o), .sec_rdata_o(sec_rdata_o),
    .shr_req_o(shr_req_o), .shr_gnt_i(shr_gnt_i), .shr_addr_o(shr_addr_o), .shr_we_o(shr_we_o),
    .shr_be_o(shr_be_o), .shr_wdata_o(shr_wdata_o), .shr_rvalid_i(shr_rvalid_i), .shr_rdata_i(shr_rdata_i),
    .outstanding_o(outstanding_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: who won last, pending locked owner, and a queue of read issuers.
  int m_last;
  bit m_locked;
  int m_lock_owner;
  int q[$];
  bit m_pri_hs, m_sec_hs;

  task automatic mdl_reset();
    m_last = 1; m_locked = 0; m_lock_owner = 0; q.delete();
    m_pri_hs = 0; m_sec_hs = 0;
  endtask

  task automatic set_pri(input bit req, input bit we, input logic [31:0] addr);
    pri_req_i = req; pri_we_i = we; pri_addr_i = addr;
    pri_be_i = 4'($urandom); pri_wdata_i = $urandom;
  endtask

  task automatic set_sec(input bit req, input bit we, input logic [31:0] addr);
    sec_req_i = req; sec_we_i = we; sec_addr_i = addr;
    sec_be_i = 4'($urandom); sec_wdata_i = $urandom;
  endtask

  // Called at a falling edge with inputs applied; checks outputs, advances one cycle.
  task automatic step();
    int owner, head;
    bit p, s, req, gnt, hs, we, full, rv;
    #1;
    p = pri_req_i; s = sec_req_i;
    if (m_locked)   owner = m_lock_owner;
    else if (p && s) owner = 1 - m_last;
    else if (s)      owner = 1;
    else             owner = 0;
    req  = (owner == 1) ? s : p;
    we   = (owner == 1) ? sec_we_i : pri_we_i;
    full = (q.size() == DEPTH);
    gnt  = shr_gnt_i && !full;
    hs   = req && gnt;
    rv   = shr_rvalid_i && (q.size() > 0);
    head = rv ? q[0] : 0;
    check("pri_gnt", pri_gnt_o, gnt && owner == 0);
    check("sec_gnt", sec_gnt_o, gnt && owner == 1);
    check("shr_req", shr_req_o, req);
    check("shr_addr", shr_addr_o, (owner == 1) ? sec_addr_i : pri_addr_i);
    check("shr_ctrl", {shr_we_o, shr_be_o, shr_wdata_o},
          (owner == 1) ? {sec_we_i, sec_be_i, sec_wdata_i} : {pri_we_i, pri_be_i, pri_wdata_i});
    check("pri_rvalid", pri_rvalid_o, rv && head == 0);
    check("sec_rvalid", sec_rvalid_o, rv && head == 1);
    check("pri_rdata", pri_rdata_o, (rv && head == 0) ? shr_rdata_i : 32'h0);
    check("sec_rdata", sec_rdata_o, (rv && head == 1) ? shr_rdata_i : 32'h0);
    check("outstanding", outstanding_o, q.size());
    @(posedge clk_i);
    if (rv) void'(q.pop_front());
    m_pri_hs = hs && owner == 0;
    m_sec_hs = hs && owner == 1;
    if (hs) begin
      m_last = owner; m_locked = 0;
      if (!we) q.push_back(owner);
    end else begin
      m_locked = req;
      if (req) m_lock_owner = owner;
    end
    @(negedge clk_i);
  endtask

  // Raises reset mid-cycle with whatever traffic is applied and checks the immediate clear.
  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    check("rst_gnt", {pri_gnt_o, sec_gnt_o}, 2'b00);
    check("rst_req", shr_req_o, 1'b0);
    check("rst_rvalid", {pri_rvalid_o, sec_rvalid_o}, 2'b00);
    check("rst_rdata", {pri_rdata_o, sec_rdata_o}, 64'h0);
    check("rst_outstanding", outstanding_o, 0);
    mdl_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic busy_inputs();
    set_pri(1, 0, 32'h100); set_sec(1, 0, 32'h200);
    shr_gnt_i = 1; shr_rvalid_i = 1; shr_rdata_i = 32'hDEAD_BEEF;
  endtask

  task automatic drain();
    set_pri(0, 0, 0); set_sec(0, 0, 0); shr_gnt_i = 0;
    shr_rvalid_i = 1; shr_rdata_i = $urandom;
    repeat (DEPTH + 1) step();
    shr_rvalid_i = 0;
  endtask

  initial begin
    rst_i = 1'b0;
    busy_inputs();
    @(negedge clk_i);
    do_reset();

    // Tie after reset: pri, sec, pri, sec; responses with one cycle latency follow that order.
    set_pri(1, 0, 32'h100); set_sec(1, 0, 32'h200); shr_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      shr_rvalid_i = (i > 0); shr_rdata_i = 32'hA0 + i;
      #1;
      check("tie_gnt", {pri_gnt_o, sec_gnt_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) check("tie_route", {pri_rvalid_o, sec_rvalid_o}, (i % 2 == 1) ? 2'b10 : 2'b01);
      step();
    end
    drain();

    // FIFO full blocks the third read even when the slave grants or pops in the same cycle.
    busy_inputs(); do_reset();
    set_pri(1, 0, 32'h300); set_sec(0, 0, 0); shr_gnt_i = 1; shr_rvalid_i = 0;
    step(); step();
    #1;
    check("full_gnt", pri_gnt_o, 1'b0);
    check("full_req", shr_req_o, 1'b1);
    check("full_out", outstanding_o, 2);
    step();
    shr_rvalid_i = 1; shr_rdata_i = 32'h5555;
    #1;
    check("full_pop_gnt", pri_gnt_o, 1'b0);
    check("full_pop_rv", pri_rvalid_o, 1'b1);
    step();
    shr_rvalid_i = 0;
    #1;
    check("full_regrant", pri_gnt_o, 1'b1);
    step();
    drain();

    // Lock: a pri write first makes sec the tie winner, yet the pending pri read holds the slave.
    busy_inputs(); do_reset();
    set_pri(1, 1, 32'h400); set_sec(0, 0, 0); shr_gnt_i = 1; shr_rvalid_i = 0;
    step();
    set_pri(1, 0, 32'h1111_0000); shr_gnt_i = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_sec(1, 0, 32'h2222_0000);
      #1;
      check("lock_addr", shr_addr_o, 32'h1111_0000);
      step();
    end
    shr_gnt_i = 1;
    #1;
    check("lock_gnt", {pri_gnt_o, sec_gnt_o}, 2'b10);
    step();
    set_pri(0, 0, 0);
    #1;
    check("lock_next", {pri_gnt_o, sec_gnt_o}, 2'b01);
    step();
    drain();

    // Mixed: sec write, pri read, sec read; responses two cycles after each read grant.
    busy_inputs(); do_reset();
    set_pri(0, 0, 0); set_sec(1, 1, 32'h500); shr_gnt_i = 1; shr_rvalid_i = 0;
    step();
    set_sec(0, 0, 0); set_pri(1, 0, 32'h600);
    step();
    set_pri(0, 0, 0); set_sec(1, 0, 32'h700);
    step();
    set_sec(0, 0, 0); shr_rvalid_i = 1; shr_rdata_i = 32'h1234_5678;
    #1;
    check("mix_rsp1", {pri_rvalid_o, sec_rvalid_o, pri_rdata_o}, {2'b10, 32'h1234_5678});
    step();
    shr_rdata_i = 32'h8765_4321;
    #1;
    check("mix_rsp2", {pri_rvalid_o, sec_rvalid_o, sec_rdata_o}, {2'b01, 32'h8765_4321});
    step();
    #1;
    check("mix_no_third", {pri_rvalid_o, sec_rvalid_o}, 2'b00);
    step();
    shr_rvalid_i = 0;

    // Same-cycle push and pop keeps the count and routes the next response to the new issuer.
    busy_inputs(); do_reset();
    set_pri(1, 0, 32'h800); set_sec(0, 0, 0); shr_gnt_i = 1; shr_rvalid_i = 0;
    step();
    set_pri(0, 0, 0); set_sec(1, 0, 32'h900); shr_rvalid_i = 1; shr_rdata_i = 32'hCAFE;
    #1;
    check("pp_push_pop", {sec_gnt_o, pri_rvalid_o}, 2'b11);
    step();
    set_sec(0, 0, 0);
    #1;
    check("pp_out", outstanding_o, 1);
    check("pp_route", {pri_rvalid_o, sec_rvalid_o}, 2'b01);
    step();
    shr_rvalid_i = 0;

    // Async reset with two reads in flight; a later response must be dropped.
    busy_inputs(); do_reset();
    shr_rvalid_i = 0;
    step(); step();
    shr_rvalid_i = 1;
    #1;
    check("ar_out_before", outstanding_o, 2);
    do_reset();
    set_pri(0, 0, 0); set_sec(0, 0, 0); shr_rvalid_i = 1;
    #1;
    check("ar_drop", {pri_rvalid_o, sec_rvalid_o}, 2'b00);
    step();
    shr_rvalid_i = 0;

    // Randomized OBI-compliant traffic: a master holds its request until granted.
    busy_inputs(); do_reset();
    set_pri(0, 0, 0); set_sec(0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (!pri_req_i || m_pri_hs) set_pri(($urandom % 3) != 0, ($urandom % 4) == 0, $urandom);
      if (!sec_req_i || m_sec_hs) set_sec(($urandom % 3) != 0, ($urandom % 4) == 0, $urandom);
      shr_gnt_i    = ($urandom % 4) != 0;
      shr_rvalid_i = ($urandom % 3) == 0;
      shr_rdata_i  = $urandom;
      if (i % 1000 == 999) do_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
